edac_4bit_enc: RTL and testbench

Write-side companion to the 4-bit EDAC read checker: accepts a 16-bit data word from the bus side on a write strobe, computes the 8-bit check field as two independent CRC-4 codes (one per byte) with a bit-serial LFSR, and presents data plus check field to memory with a one-cycle valid pulse. Its output field is exactly what the read checker later receives on its CRC input, so a write through this block followed by a read of the same location must verify clean.

---
 rtl/edac_4bit_enc_if.sv | 31 +++
 rtl/edac_4bit_enc.sv | 88 ++++++++
 tb/tb_edac_4bit_enc.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/edac_4bit_enc_if.sv
// Bus-side bundle for the 4-bit EDAC write encoder.
// INJ exists only when EDAC_ENC_ERRINJ_EN is defined.
interface edac_4bit_enc_if;
  logic        en;
  logic        WRITE;
  logic [15:0] DIN;
  logic [15:0] DOUT;
  logic [7:0]  CRC;
  logic        valid;
  logic        busy;
  logic        OVR;
`ifdef EDAC_ENC_ERRINJ_EN
  logic [15:0] INJ;
`endif

  modport master (
    output en, WRITE, DIN,
`ifdef EDAC_ENC_ERRINJ_EN
    output INJ,
`endif
    input  DOUT, CRC, valid, busy, OVR
  );

  modport slave (
    input  en, WRITE, DIN,
`ifdef EDAC_ENC_ERRINJ_EN
    input  INJ,
`endif
    output DOUT, CRC, valid, busy, OVR
  );
endinterface

// File: rtl/edac_4bit_enc.sv
// Write-side EDAC encoder: two bit-serial CRC-4 (x^4+x+1) codes, one per byte.
// Optional error injection on DOUT when EDAC_ENC_ERRINJ_EN is defined.
module edac_4bit_enc (
  input logic             CLK,
  input logic             RST_N,
  edac_4bit_enc_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [15:0] shreg;
  logic [3:0]  lfsr_hi;
  logic [3:0]  lfsr_lo;
  logic [3:0]  next_hi;
  logic [3:0]  next_lo;
  logic        req;

  // One MSB-first step of the x^4+x+1 LFSR with zero init.
  function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  always_comb begin
    req     = bus.en && bus.WRITE;
    next_hi = crc4_step(lfsr_hi, shreg[{1'b1, cnt}]);
    next_lo = crc4_step(lfsr_lo, shreg[{1'b0, cnt}]);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      shreg     <= 16'h0000;
      lfsr_hi   <= 4'h0;
      lfsr_lo   <= 4'h0;
      bus.DOUT  <= 16'h0000;
      bus.CRC   <= 8'h00;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
      bus.OVR   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            shreg    <= bus.DIN;
`ifdef EDAC_ENC_ERRINJ_EN
            bus.DOUT <= bus.DIN ^ bus.INJ;
`else
            bus.DOUT <= bus.DIN;
`endif
            lfsr_hi  <= 4'h0;
            lfsr_lo  <= 4'h0;
            cnt      <= 3'd7;
            bus.busy <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (req)
            bus.OVR <= 1'b1;
          lfsr_hi <= next_hi;
          lfsr_lo <= next_lo;
          // The last data bit is folded in on the same edge that publishes CRC.
          if (cnt == 3'd0) begin
            bus.CRC   <= {next_hi, next_lo};
            bus.valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          if (req)
            bus.OVR <= 1'b1;
          bus.valid <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edac_4bit_enc.sv
// Self-checking bench for edac_4bit_enc: vector table, cycle-exact corner
// sequences and random words against a polynomial-division CRC model.
module tb_edac_4bit_enc;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  edac_4bit_enc_if bus ();

  edac_4bit_enc dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] din;
    logic [7:0]  crc;
  } vec_t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Remainder of b*x^4 divided by x^4+x+1 via long division.
  function automatic logic [3:0] crc4_model(input logic [7:0] b);
    logic [11:0] r;
    r = {b, 4'h0};
    for (int i = 11; i >= 4; i--)
      if (r[i])
        r = r ^ (12'h013 << (i - 4));
    return r[3:0];
  endfunction

  function automatic logic [7:0] crc8_model(input logic [15:0] d);
    return {crc4_model(d[15:8]), crc4_model(d[7:0])};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic e, input logic w,
                                input logic [15:0] d, input logic [15:0] m);
    bus.en    = e;
    bus.WRITE = w;
    bus.DIN   = d;
`ifdef EDAC_ENC_ERRINJ_EN
    bus.INJ   = m;
`else
    if (m != 16'h0) bus.DIN = d;
`endif
  endtask

  // Accept one word, wait (bounded) for valid, capture results, return to IDLE.
  task automatic encode_word(input logic [15:0] d, input logic [15:0] m,
                             output logic [15:0] dout_got,
                             output logic [7:0] crc_got, output int lat);
    apply_stimulus(1'b1, 1'b1, d, m);
    tick;
    apply_stimulus(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    lat = 0;
    while (!bus.valid && lat < 20) begin
      tick;
      lat++;
    end
    dout_got = bus.DOUT;
    crc_got  = bus.CRC;
    tick;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0);
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    vec_t        vecs[5];
    logic [15:0] dout_got;
    logic [7:0]  crc_got;
    logic [15:0] din;
    logic [15:0] inj;
    logic [15:0] eff_inj;
    int          lat;
    int          pulses;

    compared   = 0;
    mismatched = 0;

    vecs[0] = '{din: 16'h0180, crc: 8'h3E};
    vecs[1] = '{din: 16'h0000, crc: 8'h00};
    vecs[2] = '{din: 16'hFFFF, crc: 8'h44};
    vecs[3] = '{din: 16'h8001, crc: 8'hE3};
    vecs[4] = '{din: 16'h0102, crc: 8'h36};

    // Reset held with an active request pending.
    rst_n = 1'b0;
    apply_stimulus(1'b1, 1'b1, 16'hFFFF, 16'h0);
    tick;
    tick;
    check_output("rst_dout", bus.DOUT, 16'h0000);
    check_output("rst_crc", bus.CRC, 8'h00);
    check_output("rst_valid", bus.valid, 1'b0);
    check_output("rst_busy", bus.busy, 1'b0);
    check_output("rst_ovr", bus.OVR, 1'b0);
    apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0);
    rst_n = 1'b1;
    tick;
    check_output("rel_busy", bus.busy, 1'b0);
    check_output("rel_ovr", bus.OVR, 1'b0);

    // en without WRITE is ignored.
    apply_stimulus(1'b1, 1'b0, 16'h5A5A, 16'h0);
    tick;
    tick;
    check_output("nowrite_busy", bus.busy, 1'b0);
    check_output("nowrite_dout", bus.DOUT, 16'h0000);
    check_output("nowrite_ovr", bus.OVR, 1'b0);
    apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0);
    tick;

    // Cycle-exact timing of one word.
    apply_stimulus(1'b1, 1'b1, 16'h0180, 16'h0);
    tick;
    apply_stimulus(1'b0, 1'b0, 16'hAAAA, 16'h0);
    check_output("basic_busy_k", bus.busy, 1'b1);
    check_output("basic_dout_k", bus.DOUT, 16'h0180);
    check_output("basic_valid_k", bus.valid, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      tick;
      check_output($sformatf("basic_busy_k+%0d", i), bus.busy, (i <= 8) ? 1'b1 : 1'b0);
      check_output($sformatf("basic_valid_k+%0d", i), bus.valid, (i == 8) ? 1'b1 : 1'b0);
      if (i == 8) begin
        check_output("basic_crc", bus.CRC, 8'h3E);
        check_output("basic_dout", bus.DOUT, 16'h0180);
      end
    end
    check_output("basic_ovr", bus.OVR, 1'b0);

    // Overrun: requests at k+4 and k+9 are dropped; next accept at k+10.
    apply_stimulus(1'b1, 1'b1, 16'h0180, 16'h0);
    tick;
    apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 1; i <= 9; i++) begin
      if (i == 4 || i == 9)
        apply_stimulus(1'b1, 1'b1, 16'h1234, 16'h0);
      tick;
      apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0);
      if (i == 4)
        check_output("ovr_set_k+4", bus.OVR, 1'b1);
      if (i == 8) begin
        check_output("ovr_valid", bus.valid, 1'b1);
        check_output("ovr_crc", bus.CRC, 8'h3E);
        check_output("ovr_dout", bus.DOUT, 16'h0180);
      end
    end
    check_output("ovr_k+9_busy", bus.busy, 1'b0);
    check_output("ovr_k+9_dout", bus.DOUT, 16'h0180);
    encode_word(16'hFFFF, 16'h0, dout_got, crc_got, lat);
    check_output("ovr_next_crc", crc_got, 8'h44);
    check_output("ovr_next_lat", lat, 8);
    check_output("ovr_sticky", bus.OVR, 1'b1);
    do_reset;
    check_output("ovr_cleared", bus.OVR, 1'b0);

    // Reset mid-encode aborts without a valid pulse.
    apply_stimulus(1'b1, 1'b1, 16'hFFFF, 16'h0);
    tick;
    apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 1; i <= 4; i++) tick;
    rst_n = 1'b0;
    tick;
    check_output("abort_crc", bus.CRC, 8'h00);
    check_output("abort_dout", bus.DOUT, 16'h0000);
    check_output("abort_busy", bus.busy, 1'b0);
    check_output("abort_valid", bus.valid, 1'b0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (bus.valid) pulses++;
    end
    check_output("abort_no_pulse", pulses, 0);

    // Known-answer vectors.
    for (int i = 0; i < 5; i++) begin
      encode_word(vecs[i].din, 16'h0, dout_got, crc_got, lat);
      check_output($sformatf("vec%0d_crc", i), crc_got, vecs[i].crc);
      check_output($sformatf("vec%0d_dout", i), dout_got, vecs[i].din);
      check_output($sformatf("vec%0d_lat", i), lat, 8);
    end

`ifdef EDAC_ENC_ERRINJ_EN
    encode_word(16'h0180, 16'h0001, dout_got, crc_got, lat);
    check_output("inj_dout", dout_got, 16'h0181);
    check_output("inj_crc", crc_got, 8'h3E);
    check_output("inj_detect", (crc8_model(dout_got) != crc_got) ? 1'b1 : 1'b0, 1'b1);
    encode_word(16'h0180, 16'h0000, dout_got, crc_got, lat);
    check_output("inj_clean", (crc8_model(dout_got) == crc_got) ? 1'b1 : 1'b0, 1'b1);
`endif

    // Random words against the reference model.
    for (int i = 0; i < 40; i++) begin
      din = 16'($urandom);
      inj = 16'($urandom);
`ifdef EDAC_ENC_ERRINJ_EN
      eff_inj = inj;
`else
      eff_inj = 16'h0;
`endif
      encode_word(din, eff_inj, dout_got, crc_got, lat);
      check_output($sformatf("rnd%0d_crc", i), crc_got, crc8_model(din));
      check_output($sformatf("rnd%0d_dout", i), dout_got, din ^ eff_inj);
      check_output($sformatf("rnd%0d_lat", i), lat, 8);
    end
    check_output("final_ovr", bus.OVR, 1'b0);
    check_output("final_busy", bus.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
